// File: rtl/gray_sync_decoder.sv
// Gray-code crossing receiver: synchronizes a gray count from a foreign clock
// domain, decodes it to binary, and reports step direction and illegal
// (multi-bit) transitions between accepted words.
module gray_sync_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir,
  output logic             step_err
);

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] bin_out_q,   bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             dir_q,       dir_d;
  logic             step_err_q,  step_err_d;

  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] gray_diff;
  logic             accept;
  logic             illegal;

  // Two-flop synchronizer; nothing may sit between the flops so the second
  // stage gets a full cycle to resolve metastability.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gray_in;
      sync2_q <= sync1_q;
    end
  end

  assign decoded   = gray2bin(sync2_q);
  assign bin_inc   = bin_out_q + WIDTH'(1);
  assign gray_diff = sync2_q ^ prev_gray_q;
  assign accept    = en && (gray_diff != '0);
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign illegal   = (gray_diff & (gray_diff - WIDTH'(1))) != '0;

  // Next-state logic for the accept path and the sticky error flag.
  // NOTE: every always_comb output is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    prev_gray_d = prev_gray_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    dir_d       = dir_q;
    step_err_d  = step_err_q;

    if (accept) begin
      prev_gray_d = sync2_q;
      bin_out_d   = decoded;
      bin_valid_d = 1'b1;
      dir_d       = !illegal && (decoded == bin_inc);
    end

    // A new illegal accept wins over a clear on the same edge. While the
    // decoder is disabled the flag is frozen along with the rest of the state.
    if (accept && illegal) begin
      step_err_d = 1'b1;
    end else if (en && err_clr) begin
      step_err_d = 1'b0;
    end
  end

  // Output and reference registers; reset makes gray 0 the accepted reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      dir_q       <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      dir_q       <= dir_d;
      step_err_q  <= step_err_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign dir       = dir_q;
  assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=4): a per-cycle vector table for
// the counting, wrap, illegal-step, error-clear and enable-gate behaviour, plus
// hand-written sequences for reset at start-up and reset mid-operation.
module tb_gray_sync_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       en;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       dir;
  logic       step_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] gray;
    logic       en;
    logic       clr;
    logic [3:0] bin;
    logic       vld;
    logic       dir;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  gray_sync_decoder #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .en       (en),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .dir      (dir),
    .step_err (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] b, input logic v,
                           input logic d, input logic e);
    check({tag, " bin_out"},   bin_out,            b);
    check({tag, " bin_valid"}, {3'b000, bin_valid}, {3'b000, v});
    check({tag, " dir"},       {3'b000, dir},       {3'b000, d});
    check({tag, " step_err"},  {3'b000, step_err},  {3'b000, e});
  endtask

  function automatic vec_t mk(input logic [3:0] g, input logic e, input logic c,
                              input logic [3:0] b, input logic vl, input logic d,
                              input logic er);
    vec_t r;
    r.gray = g; r.en = e; r.clr = c;
    r.bin = b;  r.vld = vl; r.dir = d; r.err = er;
    return r;
  endfunction

  // A new gray word held for three cycles: the first two rows still show the
  // old outputs, the third row carries the one-cycle valid pulse.
  task automatic push_step(input logic [3:0] g, input logic [3:0] old_bin, input logic old_dir,
                           input logic old_err, input logic [3:0] new_bin,
                           input logic new_dir, input logic new_err);
    vecs.push_back(mk(g, 1'b1, 1'b0, old_bin, 1'b0, old_dir, old_err));
    vecs.push_back(mk(g, 1'b1, 1'b0, old_bin, 1'b0, old_dir, old_err));
    vecs.push_back(mk(g, 1'b1, 1'b0, new_bin, 1'b1, new_dir, new_err));
  endtask

  initial begin
    //          gray     old bin/dir/err        new bin/dir/err
    push_step(4'b0001, 4'd0,  1'b0, 1'b0, 4'd1,  1'b1, 1'b0); // first +1 after reset
    push_step(4'b0011, 4'd1,  1'b1, 1'b0, 4'd2,  1'b1, 1'b0); // +1
    push_step(4'b0001, 4'd2,  1'b1, 1'b0, 4'd1,  1'b0, 1'b0); // -1
    push_step(4'b0000, 4'd1,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0); // -1
    push_step(4'b1000, 4'd0,  1'b0, 1'b0, 4'd15, 1'b0, 1'b0); // 0 -> 15 legal -1
    push_step(4'b0000, 4'd15, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0); // 15 -> 0 wrap +1
    push_step(4'b0011, 4'd0,  1'b1, 1'b0, 4'd2,  1'b0, 1'b1); // illegal 2-bit step
    push_step(4'b0010, 4'd2,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1); // legal, error sticks
    // err_clr for one cycle clears the flag
    vecs.push_back(mk(4'b0010, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    // illegal 3-bit step with err_clr on the accepting edge: flag stays set
    vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0));
    push_step(4'b0001, 4'd6,  1'b0, 1'b0, 4'd1,  1'b0, 1'b0); // legal jump 6 -> 1
    // enable gate: gray moves 0001 -> 0011 -> 0010 with en=0, outputs frozen
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0011, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0));
    // en back on: one accept of 0010 against held 0001 (2-bit step, illegal)
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1));

    // Start-up reset with gray_in already at 0001.
    rst_n   = 1'b0;
    gray_in = 4'b0001;
    en      = 1'b1;
    err_clr = 1'b0;
    #1;
    check_all("reset t0", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset edge", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      gray_in = vecs[i].gray;
      en      = vecs[i].en;
      err_clr = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].vld, vecs[i].dir, vecs[i].err);
    end

    // Reset mid-operation while 1110 sits in the synchronizer.
    gray_in = 4'b1110;
    en      = 1'b1;
    err_clr = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all("midreset async", 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post-reset e1", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("post-reset e2", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("post-reset e3", 4'b1011, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_all("post-reset e4", 4'b1011, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the gray and binary word width (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port gray_in, input, WIDTH bits: gray-coded count from a foreign domain, asynchronous to clk.
REQ-005 SHALL have port en, input, 1 bit: when 1, decoded updates are accepted.
REQ-006 SHALL have port err_clr, input, 1 bit: synchronous clear of step_err.
REQ-007 SHALL have port bin_out, output, WIDTH bits: registered binary value of the last accepted gray word.
REQ-008 SHALL have port bin_valid, output, 1 bit: one-cycle pulse when bin_out takes a new value.
REQ-009 SHALL have port dir, output, 1 bit: qualified by bin_valid; 1 = step +1, 0 = step -1 or illegal step.
REQ-010 SHALL have port step_err, output, 1 bit: sticky flag for an illegal multi-bit gray transition.

Function
REQ-011 SHALL pass gray_in through a two-flop synchronizer (sync1, then sync2) with no logic between the flops.
REQ-012 SHALL decode sync2 to binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-013 SHALL hold a register prev_gray containing the last accepted sync2 value.
REQ-014 SHALL accept on a clock edge when en=1 and sync2 != prev_gray:
- bin_out <= decode(sync2).
- prev_gray <= sync2.
- bin_valid <= 1.
REQ-015 SHALL drive bin_valid to 0 on every edge where no accept occurs, so the pulse never exceeds one cycle.
REQ-016 SHALL set dir on an accept to 1 if decode(sync2) == bin_out + 1 mod 2^WIDTH, else 0.
REQ-017 SHALL treat a transition with popcount(sync2 XOR prev_gray) > 1 as illegal:
- The value is still accepted.
- dir <= 0.
- step_err <= 1.
REQ-018 SHALL hold step_err at 1 until err_clr=1 on an edge with no new illegal accept; a simultaneous illegal accept and err_clr leaves step_err at 1.
REQ-019 SHALL, while en=0, keep clocking sync1 and sync2 and hold bin_out, dir, prev_gray and step_err unchanged, with bin_valid=0.
REQ-020 SHALL, when en returns to 1, compare against the held prev_gray and perform at most one accept per edge.
REQ-021 SHALL give latency of 3 rising edges from the edge first sampling a stable new gray_in to bin_valid=1 (sync1, sync2, output register).
REQ-022 SHALL treat wrap-around as a legal +1 step with dir=1 and no error: for WIDTH=4, gray 1000 (binary 15) to 0000 (binary 0); and 0000 to 1000 as a legal -1 step.
REQ-023 SHALL update bin_out only via accepts, so it never shows a non-decoded intermediate value.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force sync1, sync2, prev_gray, bin_out, bin_valid, dir and step_err to 0, independent of clk.
REQ-025 SHALL, after rst_n deasserts, treat gray 0000 as the accepted reference and produce no bin_valid until sync2 differs from 0.
REQ-026 SHALL, on rst_n assertion mid-operation, clear all state immediately and discard any pending synchronizer contents.

Verification (WIDTH=4)
REQ-027 SHALL cover reset then count-up:
- Stimulus: rst_n pulse low; gray_in 0001 held; en=1.
- Response: outputs 0 during reset; bin_out=0001, bin_valid=1 for exactly one cycle, dir=1 on the third edge.
- Then gray_in 0011 gives bin_out=0010, dir=1.
REQ-028 SHALL cover count-down and wrap:
- Step gray_in 0011 to 0001: bin_out=0001, dir=0, step_err=0.
- Step gray_in 1000 to 0000: bin_out=0000, dir=1, step_err=0.
REQ-029 SHALL cover an illegal step:
- Step gray_in 0000 to 0011: bin_out=0010, bin_valid pulse, dir=0, step_err=1.
- step_err stays 1 over later legal steps; err_clr=1 for one cycle gives step_err=0.
- Repeat with err_clr asserted on the same edge as an illegal accept: step_err stays 1.
REQ-030 SHALL cover the enable gate:
- Stimulus: en=0, gray_in stepping 0001 to 0011 to 0010.
- Response: no bin_valid and bin_out held.
- On en=1: exactly one bin_valid pulse with bin_out=0011 and dir=0, since 0010 vs 0001 differs in 2 bits and is flagged illegal (step_err=1).
REQ-031 SHALL cover reset mid-operation:
- Stimulus: rst_n low between clock edges while gray_in=1110.
- Response: all outputs 0 immediately, before the next edge.
- After release: bin_out=1011 with bin_valid after 3 edges, dir=0 and step_err=1 since 1110 vs 0000 differs in 3 bits.
